pool_rd_sequencer: RTL and testbench
====================================

POOL_RD_SEQUENCER -- requirements
Module: pool_rd_sequencer

Interface
REQ-001 Parameters:
- W_IN, 32, input blob width in columns.
- C, 32, channel count.
- K, 3, square window size.
- STRIDE, 2, horizontal window stride.
- W_OUT, 16, output columns per row.
- RING, 5, row-buffer ring depth in rows.
- ADDR_W, 13, row-buffer read address width.
- DELAY, 5, RAM-read-to-operator alignment latency in cycles.

REQ-002 Ports:
- clk, input, 1, sole clock; all logic rising-edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, pulse requesting one output row.
- start_row, input, 3, ring row index of window top row (0..RING-1).
- out_rdy, input, 1, downstream may accept a new window.
- rd_en, output, 1, rd_addr valid this cycle.
- rd_addr, output, ADDR_W, row-buffer read address.
- op_din_en, output, 1, operator input valid (aligned to RAM data).
- op_din_eop, output, 1, last element of a window.
- busy, output, 1, high from accepted start until done.
- done, output, 1, one-cycle pulse at end of row.

Function
REQ-003 Iteration order, outermost first: ox 0..W_OUT-1, ch 0..C-1, ky 0..K-1, kx 0..K-1; one read per cycle while issuing.
REQ-004 Address: row r=(start_row+ky) mod RING; col=min(ox*STRIDE+kx, W_IN-1); rd_addr=(r*W_IN+col)*C+ch, all unsigned, computed without truncation before the ADDR_W output.
REQ-005 Column clamp: reads beyond W_IN-1 repeat column W_IN-1, keeping every window exactly K*K elements.
REQ-006 FSM states and transitions:
- IDLE -> RUN on start.
- RUN -> HOLD at a window boundary when out_rdy=0.
- HOLD -> RUN when out_rdy=1.
- RUN -> DRAIN after the last read.
- DRAIN -> IDLE after DELAY cycles, with done asserted on that transition.
REQ-007 out_rdy is sampled only at a window's first element; once started, a window issues all K*K reads back-to-back regardless of out_rdy.
REQ-008 rd_en/rd_addr are registered: start accepted at edge t gives the first rd_en at cycle t+1.
REQ-009 op_din_en equals rd_en delayed exactly DELAY cycles. op_din_eop equals a (kx=K-1 and ky=K-1) tag delayed DELAY cycles and asserts only with op_din_en.
REQ-010 done asserts in the same cycle as the final op_din_eop of the row, for exactly one cycle.
REQ-011 busy=1 from the cycle after an accepted start through the done cycle inclusive.
REQ-012 start while busy is ignored with no side effect. start_row is captured only at an accepted start.
REQ-013 rd_addr holds its last value when rd_en=0; consumers use it only when rd_en=1.

Reset
REQ-014 On rst: state=IDLE; all counters and the delay line are cleared; rd_en, rd_addr, op_din_en, op_din_eop, busy and done are all 0 immediately, without waiting for a clock edge.
REQ-015 Reset mid-row aborts the row with no done pulse. The next start restarts at ox=0, ch=0.

Structure
REQ-016 Package pool_sched_pkg holds the FSM state enum and a localparam helper for window size K*K.
REQ-017 The DELAY-stage en/eop shift line is sub-module pool_sched_dly (parameter DELAY, width 2, async reset).

Verification
REQ-018 Reset, start with start_row=0, out_rdy=1 -> first four rd_addr are 0, 32, 64, 1024. op_din_en rises exactly 5 cycles after the first rd_en. op_din_eop on every 9th op_din_en.
REQ-019 start_row=4 -> first rd_addr 4096. 4th rd_addr 0 (ring wrap to row 0). 7th rd_addr 1024.
REQ-020 At ox=15, ch=0, ky=0 -> rd_addr 960, 992, 992 (clamp).
REQ-021 out_rdy=0 asserted mid-window -> that window completes all 9 reads, then no rd_en until out_rdy=1. Total 512 eops, 4608 op_din_en, exactly one done per row.
REQ-022 start pulsed while busy -> ignored; rd_addr sequence is unchanged versus the single-start run.
REQ-023 rst pulsed at read 2000 -> all outputs 0 asynchronously and no done. A new start with start_row=0 gives first rd_addr 0.

Source files
------------

// File: rtl/pool_sched_pkg.sv
// Shared state type and sizing helpers for the pooling read sequencer.
package pool_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

    function automatic int win_size(input int k);
        return k * k;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_sched_dly.sv
// Fixed-latency shift line carrying the {eop, en} pair from RAM read to operator input.
module pool_sched_dly #(
    parameter int DELAY = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [DELAY-1:0][1:0] pipe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout = pipe_q[DELAY-1];

endmodule

// File: rtl/pool_rd_sequencer.sv
// Walks one output row of K x K pooling windows over the row-buffer ring, issuing one read per cycle.
//   state    | meaning
//   IDLE     | waiting for start; all counters at zero
//   RUN      | issuing reads back-to-back
//   HOLD     | parked at a window boundary until out_rdy
//   DRAIN    | last read issued, waiting for it to reach the operator
module pool_rd_sequencer
    import pool_sched_pkg::*;
#(
    parameter int W_IN   = 32,
    parameter int C      = 32,
    parameter int K      = 3,
    parameter int STRIDE = 2,
    parameter int W_OUT  = 16,
    parameter int RING   = 5,
    parameter int ADDR_W = 13,
    parameter int DELAY  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        start_row,
    input  logic              out_rdy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              op_din_en,
    output logic              op_din_eop,
    output logic              busy,
    output logic              done
);

    localparam int OX_W = cnt_w(W_OUT);
    localparam int CH_W = cnt_w(C);
    localparam int K_W  = cnt_w(K);
    localparam int DC_W = cnt_w(DELAY);

    seq_state_e        state_q, state_d;
    logic [OX_W-1:0]   ox_q, ox_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [K_W-1:0]    ky_q, ky_d;
    logic [K_W-1:0]    kx_q, kx_d;
    logic [DC_W-1:0]   dly_cnt_q, dly_cnt_d;
    logic [2:0]        row_q, row_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              eop_q, eop_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept, active, win_first, issue, last_rd, win_last;
    logic [2:0]        row_base;
    logic [31:0]       row_full, col_full, addr_full;
    logic [1:0]        dly_out;

    assign win_first = (kx_q == '0) && (ky_q == '0);
    assign win_last  = (kx_q == K_W'(K-1)) && (ky_q == K_W'(K-1));
    assign last_rd   = win_last && (ch_q == CH_W'(C-1)) && (ox_q == OX_W'(W_OUT-1));
    // done_q marks the cycle where the FSM is already IDLE but busy is still reported.
    assign accept    = (state_q == ST_IDLE) && start && !done_q;
    assign active    = accept || (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign issue     = active && (!win_first || out_rdy);
    assign row_base  = (state_q == ST_IDLE) ? start_row : row_q;

    always_comb begin
        row_full = 32'(row_base) + 32'(ky_q);
        if (row_full >= 32'(RING)) begin
            row_full = row_full - 32'(RING);
        end
        col_full = 32'(ox_q) * 32'(STRIDE) + 32'(kx_q);
        if (col_full > 32'(W_IN - 1)) begin
            col_full = 32'(W_IN - 1);
        end
        addr_full = (row_full * 32'(W_IN) + col_full) * 32'(C) + 32'(ch_q);
    end

    always_comb begin
        ox_d = ox_q;
        ch_d = ch_q;
        ky_d = ky_q;
        kx_d = kx_q;
        if (issue) begin
            if (kx_q == K_W'(K-1)) begin
                kx_d = '0;
                if (ky_q == K_W'(K-1)) begin
                    ky_d = '0;
                    if (ch_q == CH_W'(C-1)) begin
                        ch_d = '0;
                        ox_d = (ox_q == OX_W'(W_OUT-1)) ? '0 : ox_q + OX_W'(1);
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end else begin
                    ky_d = ky_q + K_W'(1);
                end
            end else begin
                kx_d = kx_q + K_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        done_d    = 1'b0;
        row_d     = accept ? start_row : row_q;
        if (state_q == ST_DRAIN) begin
            if (dly_cnt_q == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                dly_cnt_d = dly_cnt_q - DC_W'(1);
            end
        end else if (active) begin
            if (issue && last_rd) begin
                state_d   = ST_DRAIN;
                dly_cnt_d = DC_W'(DELAY - 1);
            end else if (issue) begin
                state_d = ST_RUN;
            end else begin
                state_d = (state_q == ST_IDLE) ? ST_RUN : ST_HOLD;
            end
        end
        busy_d    = (state_d != ST_IDLE) || done_d;
        rd_en_d   = issue;
        rd_addr_d = issue ? ADDR_W'(addr_full) : rd_addr_q;
        eop_d     = issue && win_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ox_q      <= '0;
            ch_q      <= '0;
            ky_q      <= '0;
            kx_q      <= '0;
            dly_cnt_q <= '0;
            row_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            eop_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ox_q      <= ox_d;
            ch_q      <= ch_d;
            ky_q      <= ky_d;
            kx_q      <= kx_d;
            dly_cnt_q <= dly_cnt_d;
            row_q     <= row_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            eop_q     <= eop_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    pool_sched_dly #(
        .DELAY (DELAY)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({eop_q, rd_en_q}),
        .dout (dly_out)
    );

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign op_din_en  = dly_out[0];
    assign op_din_eop = dly_out[1] & dly_out[0];
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pool_rd_sequencer.sv
// Directed bench for pool_rd_sequencer with a per-cycle reference model of the read schedule.
module tb_pool_rd_sequencer;

    localparam int W_IN   = 32;
    localparam int C      = 32;
    localparam int K      = 3;
    localparam int STRIDE = 2;
    localparam int W_OUT  = 16;
    localparam int RING   = 5;
    localparam int ADDR_W = 13;
    localparam int DELAY  = 5;
    localparam int WIN    = pool_sched_pkg::win_size(K);
    localparam int TOTAL  = W_OUT * C * WIN;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        start_row = 3'd0;
    logic              out_rdy = 1'b1;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              op_din_en;
    logic              op_din_eop;
    logic              busy;
    logic              done;

    pool_rd_sequencer #(
        .W_IN(W_IN), .C(C), .K(K), .STRIDE(STRIDE), .W_OUT(W_OUT),
        .RING(RING), .ADDR_W(ADDR_W), .DELAY(DELAY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_row  (start_row),
        .out_rdy    (out_rdy),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .op_din_en  (op_din_en),
        .op_din_eop (op_din_eop),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Address of the idx-th read of a row, straight from the window walk order.
    function automatic int addr_of(input int sr, input int idx);
        int ox, rem, ch, w, ky, kx, r, col;
        ox  = idx / (C * WIN);
        rem = idx % (C * WIN);
        ch  = rem / WIN;
        w   = rem % WIN;
        ky  = w / K;
        kx  = w % K;
        r   = (sr + ky) % RING;
        col = ox * STRIDE + kx;
        if (col > W_IN - 1) col = W_IN - 1;
        return (r * W_IN + col) * C + ch;
    endfunction

    // Reference model state
    bit                row_active;
    int                rd_idx, op_idx, row_sr;
    bit                prev_out_rdy;
    bit                en_hist [DELAY];
    logic [ADDR_W-1:0] last_addr;
    // Observed per-row statistics
    int                n_rd, n_op, n_eop, n_done, cyc, first_rd_cyc, first_op_cyc;
    logic [ADDR_W-1:0] cap [TOTAL];

    bit exp_rd, exp_op, exp_eop, exp_done;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            row_active   = 1'b0;
            rd_idx       = 0;
            op_idx       = 0;
            last_addr    = '0;
            for (int i = 0; i < DELAY; i++) en_hist[i] = 1'b0;
            n_rd = 0; n_op = 0; n_eop = 0; n_done = 0;
            prev_out_rdy = out_rdy;
        end else begin
            exp_rd   = row_active && (rd_idx < TOTAL) && (((rd_idx % WIN) != 0) || prev_out_rdy);
            exp_op   = en_hist[DELAY-1];
            exp_eop  = exp_op && ((op_idx % WIN) == WIN - 1);
            exp_done = exp_op && (op_idx == TOTAL - 1);

            chk("rd_en", rd_en, exp_rd);
            if (exp_rd) begin
                chk("rd_addr", rd_addr, addr_of(row_sr, rd_idx));
                last_addr = ADDR_W'(addr_of(row_sr, rd_idx));
            end else begin
                chk("rd_addr_hold", rd_addr, last_addr);
            end
            chk("op_din_en", op_din_en, exp_op);
            chk("op_din_eop", op_din_eop, exp_eop);
            chk("done", done, exp_done);
            chk("busy", busy, row_active);

            if (rd_en) begin
                if (n_rd == 0) first_rd_cyc = cyc;
                if (n_rd < TOTAL) cap[n_rd] = rd_addr;
                n_rd++;
            end
            if (op_din_en) begin
                if (n_op == 0) first_op_cyc = cyc;
                n_op++;
            end
            if (op_din_eop) n_eop++;
            if (done) n_done++;

            for (int i = DELAY - 1; i > 0; i--) en_hist[i] = en_hist[i-1];
            en_hist[0] = exp_rd;
            if (exp_rd) rd_idx++;
            if (exp_op) op_idx++;

            if (exp_done) begin
                row_active = 1'b0;
            end else if (start && !row_active) begin
                row_active = 1'b1;
                row_sr     = int'(start_row);
                rd_idx     = 0;
                op_idx     = 0;
                n_rd = 0; n_op = 0; n_eop = 0; n_done = 0;
            end
            prev_out_rdy = out_rdy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [2:0] sr);
        tick();
        start     = 1'b1;
        start_row = sr;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_rd(input int n);
        int b = 0;
        while (n_rd < n && b < 20000) begin
            tick();
            b++;
        end
        if (n_rd < n) chk("wait_rd_timeout", n_rd, n);
    endtask

    task automatic wait_done();
        int b = 0;
        while (n_done == 0 && b < 30000) begin
            tick();
            b++;
        end
        chk("row_done_seen", n_done, 1);
    endtask

    task automatic row_totals(input string tag);
        tick();
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_eop_cnt"}, n_eop, TOTAL / WIN);
        chk({tag, "_op_cnt"}, n_op, TOTAL);
        chk({tag, "_rd_cnt"}, n_rd, TOTAL);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("reset_rd_en", rd_en, 0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        tick();

        // Plain row from ring row 0
        do_start(3'd0);
        wait_done();
        chk("a_addr0", cap[0], 0);
        chk("a_addr1", cap[1], 32);
        chk("a_addr2", cap[2], 64);
        chk("a_addr3", cap[3], 1024);
        chk("a_clamp0", cap[4320], 960);
        chk("a_clamp1", cap[4321], 992);
        chk("a_clamp2", cap[4322], 992);
        chk("a_op_latency", first_op_cyc - first_rd_cyc, 5);
        row_totals("a");

        // Ring wrap from row 4
        do_start(3'd4);
        wait_done();
        chk("b_addr0", cap[0], 4096);
        chk("b_addr3", cap[3], 0);
        chk("b_addr6", cap[6], 1024);
        row_totals("b");

        // Back-pressure: blocked at start, mid-window stall, then random out_rdy
        out_rdy = 1'b0;
        do_start(3'd0);
        repeat (5) tick();
        chk("c_no_rd_blocked", n_rd, 0);
        chk("c_busy_blocked", busy, 1);
        out_rdy = 1'b1;
        wait_rd(40);
        out_rdy = 1'b0;
        repeat (20) tick();
        chk("c_window_finished", n_rd, 45);
        repeat (10) tick();
        chk("c_still_held", n_rd, 45);
        out_rdy = 1'b1;
        begin
            int b = 0;
            while (n_done == 0 && b < 30000) begin
                tick();
                out_rdy = ($urandom_range(0, 3) != 0);
                b++;
            end
        end
        out_rdy = 1'b1;
        chk("c_row_done_seen", n_done, 1);
        row_totals("c");

        // Starts while busy must be ignored
        do_start(3'd0);
        repeat (100) tick();
        do_start(3'd3);
        wait_rd(3000);
        do_start(3'd1);
        wait_done();
        chk("d_addr0", cap[0], 0);
        chk("d_addr3", cap[3], 1024);
        chk("d_addr_mid", cap[4320], 960);
        row_totals("d");

        // Reset mid-row
        do_start(3'd0);
        wait_rd(2000);
        rst = 1'b1;
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_op_din_en", op_din_en, 0);
        chk("rst_op_din_eop", op_din_eop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("e_no_done_after_abort", n_done, 0);
        do_start(3'd0);
        repeat (3) tick();
        chk("e_restart_addr0", cap[0], 0);
        wait_done();
        chk("e_restart_addr3", cap[3], 1024);
        row_totals("e");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
